// File: rtl/calc_req_pkg.sv
// calc_req_pkg: shared types and constants for the calc1 requester driver.
//   state_t      FSM states of calc_req_driver
//   CMD_*        calc1 command codes
//   RESP_*       port response / result codes
package calc_req_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND1 = 3'd1,
        SEND2 = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;
    localparam logic [1:0] RESP_TOUT = 2'd3;

endpackage

// File: rtl/calc_req_skid.sv
// calc_req_skid: one-entry operation buffer (cmd, data1, data2) placed in
// front of the calc_req_driver FSM. Only compiled when CALC_REQ_SKID_EN is
// defined.
// Ports:
//   clk        clock, state updates on the falling edge
//   rst_n      asynchronous active-low reset, empties the buffer
//   in_valid / in_ready            upstream handshake (in_ready = buffer empty)
//   in_cmd, in_data1, in_data2     upstream operation
//   out_valid / out_ready          downstream handshake (out_valid = buffer full)
//   out_cmd, out_data1, out_data2  buffered operation
`ifdef CALC_REQ_SKID_EN
module calc_req_skid (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:3]  in_cmd,
    input  logic [0:31] in_data1,
    input  logic [0:31] in_data2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:3]  out_cmd,
    output logic [0:31] out_data1,
    output logic [0:31] out_data2
);
    logic full;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
        end else if (out_ready && full) begin
            full <= 1'b0;
        end
    end

    // Payload only matters while full is set, so it carries no reset.
    always_ff @(negedge clk) begin
        if (in_valid && !full) begin
            out_cmd   <= in_cmd;
            out_data1 <= in_data1;
            out_data2 <= in_data2;
        end
    end

    assign in_ready  = ~full;
    assign out_valid = full;

endmodule
`endif

// File: rtl/calc_req_driver.sv
// calc_req_driver: initiator side of a calc1 requester port. Takes one
// operation (cmd + two operands), serialises it onto the port as
// cmd+operand1 then operand2, waits for the response with a timeout and
// returns the result on a local valid/ready interface. All state updates
// happen on the falling edge of c_clk.
// Optional feature macro: CALC_REQ_SKID_EN adds a one-entry skid buffer so
// a second operation can be accepted while one is in flight.
// Ports:
//   c_clk, reset                       clock (negedge), async active-low reset
//   op_valid/op_ready, op_cmd,
//   op_data1, op_data2                 local operation input
//   req_cmd_out, req_data_out          registered drive into the port
//   out_resp, out_data                 port response (out_resp 0 = none)
//   res_valid/res_ready, res_code,
//   res_data, res_timeout              local result output
//   busy                               FSM not idle
module calc_req_driver
    import calc_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_data1,
    input  logic [0:31] op_data2,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    input  logic [0:1]  out_resp,
    input  logic [0:31] out_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [0:1]  res_code,
    output logic [0:31] res_data,
    output logic        res_timeout,
    output logic        busy
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [0:3]       cmd_d;
    logic [0:31]      data_d;
    logic [0:31]      data2_q;
    logic [0:1]       code_d;
    logic [0:31]      rdata_d;
    logic             tout_d;

    logic             src_valid;
    logic [0:3]       src_cmd;
    logic [0:31]      src_data1, src_data2;
    logic             fsm_free;
    logic             take;

`ifdef CALC_REQ_SKID_EN
    // The FSM may also reload straight out of DONE once the result is taken.
    assign fsm_free = (state == IDLE) || (state == DONE && res_ready);

    calc_req_skid u_skid (
        .clk       (c_clk),
        .rst_n     (reset),
        .in_valid  (op_valid),
        .in_ready  (op_ready),
        .in_cmd    (op_cmd),
        .in_data1  (op_data1),
        .in_data2  (op_data2),
        .out_valid (src_valid),
        .out_ready (fsm_free),
        .out_cmd   (src_cmd),
        .out_data1 (src_data1),
        .out_data2 (src_data2)
    );
`else
    assign fsm_free  = (state == IDLE);
    assign op_ready  = fsm_free;
    assign src_valid = op_valid;
    assign src_cmd   = op_cmd;
    assign src_data1 = op_data1;
    assign src_data2 = op_data2;
`endif

    assign take      = fsm_free & src_valid;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cmd_d   = req_cmd_out;
        data_d  = req_data_out;
        code_d  = res_code;
        rdata_d = res_data;
        tout_d  = res_timeout;

        case (state)
            SEND1: begin
                state_d = SEND2;
                cmd_d   = '0;
                data_d  = data2_q;
            end
            SEND2: begin
                state_d = WAIT;
                cmd_d   = '0;
                data_d  = '0;
                cnt_d   = '0;
            end
            WAIT: begin
                // A response on the timeout edge still wins.
                if (out_resp != RESP_NONE) begin
                    state_d = DONE;
                    code_d  = out_resp;
                    rdata_d = out_data;
                    tout_d  = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    state_d = DONE;
                    code_d  = RESP_TOUT;
                    rdata_d = '0;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                    code_d  = '0;
                    rdata_d = '0;
                    tout_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Start of a new operation overrides the IDLE / DONE-exit defaults.
        if (take) begin
            if (src_cmd != CMD_NOP) begin
                state_d = SEND1;
                cmd_d   = src_cmd;
                data_d  = src_data1;
            end else begin
                state_d = DONE;
                code_d  = RESP_ERR;
                rdata_d = '0;
                tout_d  = 1'b0;
            end
        end
    end

    always_ff @(negedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            res_code     <= '0;
            res_data     <= '0;
            res_timeout  <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            req_cmd_out  <= cmd_d;
            req_data_out <= data_d;
            res_code     <= code_d;
            res_data     <= rdata_d;
            res_timeout  <= tout_d;
        end
    end

    // Operand 2 is only read in SEND1, right after it is captured.
    always_ff @(negedge c_clk) begin
        if (take) begin
            data2_q <= src_data2;
        end
    end

endmodule
